// File: rtl/rx_cmd_controller_pkg.sv
// Shared ALU-UART definitions: command codes, FSM states, operand widths.
package rx_cmd_controller_pkg;

    localparam int OPERAND_W = 8;
    localparam int OPCODE_W  = 6;

    localparam logic [7:0] CMD_LOAD_A  = 8'h01;
    localparam logic [7:0] CMD_LOAD_B  = 8'h02;
    localparam logic [7:0] CMD_LOAD_OP = 8'h03;
    localparam logic [7:0] CMD_DISPLAY = 8'h04;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_WAIT_DATA    = 2'd1,
        S_WAIT_TX_FREE = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2,
        SEL_OP   = 2'd3
    } load_sel_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [7:0] b);
        return b[OPCODE_W-1:0];
    endfunction

endpackage

// File: rtl/rx_cmd_controller_timeout_timer.sv
// Counts idle cycles while waiting for a load data byte; expired is held at the last count.
module rx_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LAST_COUNT);
    assign expired   = w_at_last;

    // Counter saturates at the last value so expired cannot wrap back low.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= {CNT_W{1'b0}};
        end else if (enable && !w_at_last) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/rx_cmd_controller.sv
// Decodes UART command bytes into ALU operand/opcode loads and display requests.
module rx_cmd_controller
    import rx_cmd_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_done_pulse,
    input  logic                tx_busy,
    output logic [OPERAND_W-1:0] op_a,
    output logic [OPERAND_W-1:0] op_b,
    output logic [OPCODE_W-1:0]  op_code,
    output logic                display_cmd_pulse,
    output logic                cmd_error
);

    rx_state_t              r_state;
    rx_state_t              w_state_next;
    load_sel_t              r_sel;
    load_sel_t              w_sel_next;
    logic [OPERAND_W-1:0]   r_op_a;
    logic [OPERAND_W-1:0]   r_op_b;
    logic [OPCODE_W-1:0]    r_op_code;
    logic                   r_display;
    logic                   r_error;
    logic                   w_display_next;
    logic                   w_error_next;
    logic                   w_wr_a;
    logic                   w_wr_b;
    logic                   w_wr_op;
    logic                   w_timer_clear;
    logic                   w_timer_en;
    logic                   w_expired;

    rx_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_timer_clear),
        .enable  (w_timer_en),
        .expired (w_expired)
    );

    // Next-state, load strobes and pulse requests.
    always_comb begin
        w_state_next   = r_state;
        w_sel_next     = r_sel;
        w_display_next = 1'b0;
        w_error_next   = 1'b0;
        w_wr_a         = 1'b0;
        w_wr_b         = 1'b0;
        w_wr_op        = 1'b0;
        w_timer_clear  = 1'b0;
        w_timer_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_clear = 1'b1;
                if (rx_done_pulse) begin
                    case (rx_data)
                        CMD_LOAD_A: begin
                            w_sel_next   = SEL_A;
                            w_state_next = S_WAIT_DATA;
                        end
                        CMD_LOAD_B: begin
                            w_sel_next   = SEL_B;
                            w_state_next = S_WAIT_DATA;
                        end
                        CMD_LOAD_OP: begin
                            w_sel_next   = SEL_OP;
                            w_state_next = S_WAIT_DATA;
                        end
                        CMD_DISPLAY: begin
                            if (tx_busy) begin
                                w_state_next = S_WAIT_TX_FREE;
                            end else begin
                                w_display_next = 1'b1;
                            end
                        end
                        default: w_error_next = 1'b1;
                    endcase
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_DATA: begin
                // A data byte arriving on the expiry cycle still counts as data.
                if (rx_done_pulse) begin
                    case (r_sel)
                        SEL_A:   w_wr_a  = 1'b1;
                        SEL_B:   w_wr_b  = 1'b1;
                        SEL_OP:  w_wr_op = 1'b1;
                        default: w_wr_a  = 1'b0;
                    endcase
                    w_sel_next   = SEL_NONE;
                    w_state_next = S_IDLE;
                end else if (w_expired) begin
                    w_error_next = 1'b1;
                    w_sel_next   = SEL_NONE;
                    w_state_next = S_IDLE;
                end else begin
                    w_timer_en = 1'b1;
                end
            end
            S_WAIT_TX_FREE: begin
                if (rx_done_pulse) begin
                    w_error_next = 1'b1;
                end else begin
                    w_error_next = 1'b0;
                end
                if (!tx_busy) begin
                    w_display_next = 1'b1;
                    w_state_next   = S_IDLE;
                end else begin
                    w_state_next = S_WAIT_TX_FREE;
                end
            end
            default: begin
                w_sel_next   = SEL_NONE;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, selector, operand registers and registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sel     <= SEL_NONE;
            r_op_a    <= 8'h00;
            r_op_b    <= 8'h00;
            r_op_code <= 6'h00;
            r_display <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sel     <= w_sel_next;
            r_display <= w_display_next;
            r_error   <= w_error_next;
            if (w_wr_a) begin
                r_op_a <= rx_data;
            end
            if (w_wr_b) begin
                r_op_b <= rx_data;
            end
            if (w_wr_op) begin
                r_op_code <= opcode_of(rx_data);
            end
        end
    end

    assign op_a              = r_op_a;
    assign op_b              = r_op_b;
    assign op_code           = r_op_code;
    assign display_cmd_pulse = r_display;
    assign cmd_error         = r_error;

endmodule

// File: tb/tb_rx_cmd_controller.sv
// Directed plus randomized bench for rx_cmd_controller against a transaction-level model.
module tb_rx_cmd_controller;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_pulse = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [5:0] op_code;
    logic       display_cmd_pulse;
    logic       cmd_error;

    rx_cmd_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .reset             (reset),
        .rx_data           (rx_data),
        .rx_done_pulse     (rx_done_pulse),
        .tx_busy           (tx_busy),
        .op_a              (op_a),
        .op_b              (op_b),
        .op_code           (op_code),
        .display_cmd_pulse (display_cmd_pulse),
        .cmd_error         (cmd_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int disp_cnt = 0;
    int err_cnt = 0;
    int dbl_cnt = 0;
    logic prev_disp = 1'b0;
    logic prev_err = 1'b0;

    // Model state: expected registers and expected event totals.
    logic [7:0] exp_a, exp_b, exp_op;
    int exp_disp = 0;
    int exp_err = 0;

    // Pulse monitor: counts pulses and flags any pulse lasting two cycles.
    always @(posedge clk) begin
        if (display_cmd_pulse === 1'b1) disp_cnt++;
        if (cmd_error === 1'b1) err_cnt++;
        if (display_cmd_pulse === 1'b1 && prev_disp === 1'b1) dbl_cnt++;
        if (cmd_error === 1'b1 && prev_err === 1'b1) dbl_cnt++;
        prev_disp = display_cmd_pulse;
        prev_err  = cmd_error;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done_pulse = 1'b1;
        @(negedge clk);
        rx_done_pulse = 1'b0;
    endtask

    // Higher-level model of a completed load transaction.
    function automatic void model_load(input logic [7:0] cmd, input logic [7:0] data);
        if (cmd == 8'h01) exp_a = data;
        else if (cmd == 8'h02) exp_b = data;
        else if (cmd == 8'h03) exp_op = {2'b00, data[5:0]};
    endfunction

    // gap = idle cycles between command and data; up to TO-2 is accepted.
    task automatic do_load(input logic [7:0] cmd, input logic [7:0] data, input int gap);
        send(cmd);
        idle(gap);
        send(data);
        model_load(cmd, data);
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".op_a"}, {24'h0, op_a}, {24'h0, exp_a});
        check({tag, ".op_b"}, {24'h0, op_b}, {24'h0, exp_b});
        check({tag, ".op_code"}, {26'h0, op_code}, {24'h0, exp_op});
    endtask

    task automatic check_counts(input string tag);
        idle(2);
        check({tag, ".disp_cnt"}, disp_cnt, exp_disp);
        check({tag, ".err_cnt"}, err_cnt, exp_err);
    endtask

    initial begin
        int snap;
        logic [7:0] b;
        exp_a = 8'h00; exp_b = 8'h00; exp_op = 8'h00;

        idle(3);
        reset = 1'b0;
        check_regs("reset");
        check("reset.disp", {31'h0, display_cmd_pulse}, 32'h0);
        check("reset.err", {31'h0, cmd_error}, 32'h0);

        do_load(8'h01, 8'h5A, 0);
        do_load(8'h02, 8'hA5, 3);
        do_load(8'h03, 8'hE2, 0);
        check("load.op_code_22", {26'h0, op_code}, 32'h22);
        check_regs("loads");
        check_counts("loads");

        send(8'h04);
        check("disp_free.pulse", {31'h0, display_cmd_pulse}, 32'h1);
        idle(1);
        check("disp_free.single", {31'h0, display_cmd_pulse}, 32'h0);
        exp_disp++;

        tx_busy = 1'b1;
        send(8'h04);
        snap = disp_cnt;
        idle(39);
        check("disp_busy.none_early", disp_cnt, snap);
        check("disp_busy.low", {31'h0, display_cmd_pulse}, 32'h0);
        tx_busy = 1'b0;
        idle(1);
        check("disp_busy.pulse", {31'h0, display_cmd_pulse}, 32'h1);
        idle(1);
        check("disp_busy.single", {31'h0, display_cmd_pulse}, 32'h0);
        exp_disp++;
        check_counts("display");

        send(8'h01);
        idle(TO - 1);
        check("timeout.not_yet", {31'h0, cmd_error}, 32'h0);
        idle(1);
        check("timeout.err", {31'h0, cmd_error}, 32'h1);
        exp_err++;
        send(8'h33);
        check("timeout.invalid_after", {31'h0, cmd_error}, 32'h1);
        exp_err++;
        check_regs("timeout");
        check_counts("timeout");

        do_load(8'h02, 8'h04, 0);
        check("data_is_cmd.op_b", {24'h0, op_b}, 32'h04);
        b = 8'($urandom);
        do_load(8'h02, b, TO - 2);
        check("edge_data.no_err", {31'h0, cmd_error}, 32'h0);
        check_regs("edge_data");
        check_counts("edge_data");

        send(8'h07);
        check("inv07.err", {31'h0, cmd_error}, 32'h1);
        send(8'hFF);
        check("invFF.err", {31'h0, cmd_error}, 32'h1);
        exp_err += 2;
        tx_busy = 1'b1;
        send(8'h04);
        send(8'($urandom));
        check("wait_tx.byte_err", {31'h0, cmd_error}, 32'h1);
        exp_err++;
        idle(3);
        tx_busy = 1'b0;
        idle(1);
        check("wait_tx.still_disp", {31'h0, display_cmd_pulse}, 32'h1);
        exp_disp++;
        check_regs("invalid");
        check_counts("invalid");

        send(8'h01);
        idle(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        exp_a = 8'h00; exp_b = 8'h00; exp_op = 8'h00;
        send(8'h77);
        check("reset_mid.invalid", {31'h0, cmd_error}, 32'h1);
        exp_err++;
        tx_busy = 1'b1;
        send(8'h04);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        tx_busy = 1'b0;
        idle(3);
        check_regs("reset_mid");
        check_counts("reset_mid");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: do_load(8'($urandom_range(1, 3)), 8'($urandom), $urandom_range(0, TO - 2));
                1: begin
                    b = 8'($urandom_range(0, 251));
                    if (b != 8'h00) b = b + 8'h04;
                    send(b);
                    exp_err++;
                end
                2: begin
                    send(8'h04);
                    exp_disp++;
                end
                3: begin
                    tx_busy = 1'b1;
                    send(8'h04);
                    idle($urandom_range(1, 10));
                    tx_busy = 1'b0;
                    idle(1);
                    exp_disp++;
                end
                default: begin
                    send(8'($urandom_range(1, 3)));
                    idle(TO + $urandom_range(0, 3));
                    exp_err++;
                end
            endcase
            check_regs("rand");
        end
        check_counts("rand");
        check("no_double_pulse", dbl_cnt, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_cmd_controller.md
RX_CMD_CONTROLLER -- requirements
Module: rx_cmd_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 10_000_000, maximum clk cycles allowed between a load command byte and its data byte.
REQ-002 The block SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port rx_data  input  8  byte from uart_rx, valid only when rx_done_pulse=1.
REQ-005 The block SHALL have port rx_done_pulse  input  1  one-cycle strobe marking a received byte.
REQ-006 The block SHALL have port tx_busy  input  1  uart_tx busy flag; transmit path is occupied.
REQ-007 The block SHALL have port op_a  output  8  ALU operand A register.
REQ-008 The block SHALL have port op_b  output  8  ALU operand B register.
REQ-009 The block SHALL have port op_code  output  6  ALU operation select register.
REQ-010 The block SHALL have port display_cmd_pulse  output  1  one-cycle request to the transmit controller.
REQ-011 The block SHALL have port cmd_error  output  1  one-cycle strobe on any protocol error.

Function
REQ-012 Command codes SHALL be: 0x01 LOAD_A, 0x02 LOAD_B, 0x03 LOAD_OP, 0x04 DISPLAY; every other value is invalid.
REQ-013 The FSM SHALL have states S_IDLE, S_WAIT_DATA, S_WAIT_TX_FREE.
REQ-014 In S_IDLE, a byte with rx_done_pulse=1 SHALL be decoded as a command; other cycles hold state.
REQ-015 A LOAD_A/LOAD_B/LOAD_OP command SHALL latch the target selector, clear the timeout counter, and go to S_WAIT_DATA next cycle.
REQ-016 In S_WAIT_DATA, the next received byte SHALL be written to the selected register on the following edge (op_a/op_b: full 8 bits; op_code: rx_data[5:0], bits [7:6] ignored), then return to S_IDLE.
REQ-017 A byte in S_WAIT_DATA SHALL be treated as data even if its value equals a command code.
REQ-018 In S_WAIT_DATA, the counter SHALL increment each cycle without rx_done_pulse; when it reaches TIMEOUT_CYCLES-1, next edge returns to S_IDLE, pulses cmd_error, and leaves all operand registers unchanged.
REQ-019 If rx_done_pulse coincides with the timeout cycle, the data byte SHALL win: register written, no cmd_error.
REQ-020 DISPLAY in S_IDLE with tx_busy=0 SHALL assert display_cmd_pulse for exactly one cycle, registered, on the edge after the command byte; state stays S_IDLE.
REQ-021 DISPLAY in S_IDLE with tx_busy=1 SHALL go to S_WAIT_TX_FREE; there, the first cycle sampling tx_busy=0 SHALL produce a one-cycle display_cmd_pulse on the next edge and return to S_IDLE.
REQ-022 A byte received in S_WAIT_TX_FREE SHALL be discarded and pulse cmd_error; the pending display SHALL remain pending.
REQ-023 An invalid command byte in S_IDLE SHALL pulse cmd_error for one cycle and stay in S_IDLE with no register change.
REQ-024 display_cmd_pulse and cmd_error SHALL never be high for more than one consecutive cycle per event; operand outputs change only per REQ-016.
REQ-025 Unreachable state encodings SHALL return to S_IDLE on the next edge.

Reset
REQ-026 On reset=1 at a clock edge: state=S_IDLE, op_a=0x00, op_b=0x00, op_code=6'h00, display_cmd_pulse=0, cmd_error=0, timeout counter=0, selector cleared.
REQ-027 Reset SHALL take priority over all inputs, including mid-sequence in S_WAIT_DATA or S_WAIT_TX_FREE; pending loads and displays are abandoned without error pulse.

Structure
REQ-028 Command codes, state encodings and operand/opcode widths SHALL live in the shared ALU-UART definitions header used by the transmit controller and top level.
REQ-029 The timeout counter SHALL be a sub-module rx_timeout_timer (inputs clear, enable; output expired; parameter TIMEOUT_CYCLES, width $clog2(TIMEOUT_CYCLES)).
REQ-030 The FSM SHALL use separate registered state and combinational next-state logic; outputs registered.

Verification (TIMEOUT_CYCLES=16 in bench)
REQ-031 Bytes 0x01,0x5A then 0x02,0xA5 then 0x03,0xE2 -> op_a=0x5A, op_b=0xA5, op_code=0x22, no cmd_error.
REQ-032 0x04 with tx_busy=0 -> single display_cmd_pulse one cycle after rx_done_pulse; 0x04 with tx_busy=1 held 40 cycles -> pulse exactly one cycle after tx_busy falls, none before.
REQ-033 0x01 then 16 idle cycles -> one cmd_error pulse, op_a unchanged; following 0x33 decoded as invalid command (second cmd_error).
REQ-034 0x02 then 0x04 -> op_b=0x04, no display_cmd_pulse; 0x02 with data on exact timeout cycle -> op_b written, no cmd_error.
REQ-035 0x07 and 0xFF in S_IDLE -> two cmd_error pulses, registers unchanged; byte during S_WAIT_TX_FREE -> cmd_error, display still issued later.
REQ-036 reset asserted in S_WAIT_DATA after 0x01, then 0x77 -> state S_IDLE, op_a=0x00, 0x77 flagged invalid, no display or load.
